// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default geometry, and the canned front-end control words.
package hazard_pkg;

   localparam int HAZ_DEF_REG_AW = 3;
   localparam int HAZ_DEF_MC_LAT = 4;

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } hazard_state_e;

   // One bundle of every stage-register control the unit drives.
   typedef struct packed {
      logic pcWrite;
      logic ifidWrite;
      logic ifidFlush;
      logic idexWrite;
      logic idexFlush;
      logic exmemBubble;
      logic mcBusy;
   } hazard_ctrl_t;

   // Free-running pipeline: everything advances, nothing is squashed.
   localparam hazard_ctrl_t CTRL_RUN_DEFAULT  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   // Taken branch: squash the two wrong-path instructions behind it.
   localparam hazard_ctrl_t CTRL_BRANCH_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   // Load-use: freeze PC and IF/ID, send a NOP bubble into ID/EX.
   localparam hazard_ctrl_t CTRL_LOAD_USE     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   // Multi-cycle op: hold the whole front end, feed NOPs behind EX.
   localparam hazard_ctrl_t CTRL_MC_HOLD      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next value: step only when asked and not already pinned at the top.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// fixed-latency multi-cycle EX holds. All outputs are Mealy.
// Optional feature macro: HAZARD_PERF_EN enables the stall/flush
// performance counters; without it both counter ports read 0.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW = HAZ_DEF_REG_AW,
   parameter int MC_LAT = HAZ_DEF_MC_LAT,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ID_rs,
   input  logic [REG_AW-1:0] ID_rt,
   input  logic              ID_uses_rs,
   input  logic              ID_uses_rt,
   input  logic [REG_AW-1:0] EX_rd,
   input  logic              EX_memread,
   input  logic              EX_regwrite,
   input  logic              EX_mc_start,
   input  logic              EX_branch_taken,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_write,
   output logic              idex_flush,
   output logic              exmem_bubble,
   output logic              mc_busy,
   output logic [CNT_W-1:0]  perf_stall_cnt,
   output logic [CNT_W-1:0]  perf_flush_cnt
);

   // mc_cnt holds the number of MC_BUSY cycles still to run, including the
   // current one. The start cycle itself stalls in RUN, so MC_BUSY is only
   // entered when MC_LAT-2 extra stall cycles remain (MC_LAT > 2).
   localparam logic [3:0] MC_LOAD = (MC_LAT > 2) ? 4'(MC_LAT - 2) : 4'd0;

   hazard_state_e state_q, state_d;
   logic [3:0]    mcCnt_q, mcCnt_d;
   hazard_ctrl_t  ctrl;
   logic          loadUse;

   assign loadUse = EX_memread && EX_regwrite &&
                    ((ID_uses_rs && (ID_rs == EX_rd)) ||
                     (ID_uses_rt && (ID_rt == EX_rd)));

   // Next-state and control-word selection, branch > multi-cycle > load-use.
   always_comb begin
      ctrl    = CTRL_RUN_DEFAULT;
      state_d = state_q;
      mcCnt_d = mcCnt_q;
      case (state_q)
         RUN: begin
            if (EX_branch_taken) begin
               ctrl = CTRL_BRANCH_FLUSH;
            end else if (EX_mc_start && (MC_LAT > 1)) begin
               ctrl = CTRL_MC_HOLD;
               if (MC_LAT > 2) begin
                  state_d = MC_BUSY;
                  mcCnt_d = MC_LOAD;
               end
            end else if (loadUse) begin
               ctrl = CTRL_LOAD_USE;
            end
         end
         MC_BUSY: begin
            ctrl    = CTRL_MC_HOLD;
            mcCnt_d = mcCnt_q - 4'd1;
            if (mcCnt_q <= 4'd1) begin
               state_d = RUN;
               mcCnt_d = 4'd0;
            end
         end
         default: begin
            state_d = RUN;
            mcCnt_d = 4'd0;
         end
      endcase
   end

   // State register and busy counter; reset aborts any hold at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         mcCnt_q <= 4'd0;
      end else begin
         state_q <= state_d;
         mcCnt_q <= mcCnt_d;
      end
   end

   assign pc_write     = ctrl.pcWrite;
   assign ifid_write   = ctrl.ifidWrite;
   assign ifid_flush   = ctrl.ifidFlush;
   assign idex_write   = ctrl.idexWrite;
   assign idex_flush   = ctrl.idexFlush;
   assign exmem_bubble = ctrl.exmemBubble;
   assign mc_busy      = ctrl.mcBusy;

`ifdef HAZARD_PERF_EN
   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (~ctrl.pcWrite),
      .count_o (perf_stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (ctrl.ifidFlush),
      .count_o (perf_flush_cnt)
   );
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit (MC_LAT = 4).
// Expected control words and counter values are queued as each cycle is
// driven, then popped and compared against the DUT mid-cycle.
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mc_busy}
   localparam logic [6:0] EXP_DEF = 7'b1101000;
   localparam logic [6:0] EXP_LU  = 7'b0001100;
   localparam logic [6:0] EXP_BR  = 7'b1111100;
   localparam logic [6:0] EXP_MC  = 7'b0000011;

   typedef struct packed {
      logic [6:0]  ctrl;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  ID_rs = '0, ID_rt = '0, EX_rd = '0;
   logic        ID_uses_rs = 1'b0, ID_uses_rt = 1'b0;
   logic        EX_memread = 1'b0, EX_regwrite = 1'b0;
   logic        EX_mc_start = 1'b0, EX_branch_taken = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic        exmem_bubble, mc_busy;
   logic [15:0] perf_stall_cnt, perf_flush_cnt;

   exp_t        scoreboard[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] modelStall = '0;
   logic [15:0] modelFlush = '0;

   hazard_control_unit #(.REG_AW(3), .MC_LAT(4), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .ID_rs           (ID_rs),
      .ID_rt           (ID_rt),
      .ID_uses_rs      (ID_uses_rs),
      .ID_uses_rt      (ID_uses_rt),
      .EX_rd           (EX_rd),
      .EX_memread      (EX_memread),
      .EX_regwrite     (EX_regwrite),
      .EX_mc_start     (EX_mc_start),
      .EX_branch_taken (EX_branch_taken),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_write      (idex_write),
      .idex_flush      (idex_flush),
      .exmem_bubble    (exmem_bubble),
      .mc_busy         (mc_busy),
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Queue the expected outputs for the cycle just driven.
   task automatic pushExpected(input logic [6:0] expCtrl);
      exp_t e;
      e.ctrl  = expCtrl;
      e.stall = PERF_EN ? modelStall : 16'd0;
      e.flush = PERF_EN ? modelFlush : 16'd0;
      scoreboard.push_back(e);
   endtask

   // Pop one expectation and compare control word and both counters.
   task automatic checkOutput(input string tag);
      exp_t       e;
      logic [6:0] obs;
      obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mc_busy};
      vectors++;
      assert (scoreboard.size() != 0)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed empty scoreboard, expected an entry", tag);
      end
      if (scoreboard.size() != 0) begin
         e = scoreboard.pop_front();
         assert (obs === e.ctrl)
         else begin
            miscompares++;
            $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, obs, e.ctrl);
         end
         vectors++;
         assert (perf_stall_cnt === e.stall)
         else begin
            miscompares++;
            $error("[TB] FAIL %s stall_cnt: observed %0d expected %0d", tag, perf_stall_cnt, e.stall);
         end
         vectors++;
         assert (perf_flush_cnt === e.flush)
         else begin
            miscompares++;
            $error("[TB] FAIL %s flush_cnt: observed %0d expected %0d", tag, perf_flush_cnt, e.flush);
         end
      end
   endtask

   // Drive one cycle of inputs after the clock edge, check it mid-cycle,
   // then account for what the coming edge will do to the counters.
   task automatic applyStimulus(input logic memread, input logic regwrite,
                                input logic [2:0] exRd, input logic [2:0] idRs,
                                input logic [2:0] idRt, input logic usesRs,
                                input logic usesRt, input logic mcStart,
                                input logic branch, input logic [6:0] expCtrl,
                                input string tag);
      @(posedge clk);
      #1;
      EX_memread      = memread;
      EX_regwrite     = regwrite;
      EX_rd           = exRd;
      ID_rs           = idRs;
      ID_rt           = idRt;
      ID_uses_rs      = usesRs;
      ID_uses_rt      = usesRt;
      EX_mc_start     = mcStart;
      EX_branch_taken = branch;
      pushExpected(expCtrl);
      #3;
      checkOutput(tag);
      if (!expCtrl[6] && (modelStall != 16'hFFFF)) modelStall = modelStall + 16'd1;
      if (expCtrl[4] && (modelFlush != 16'hFFFF)) modelFlush = modelFlush + 16'd1;
   endtask

   task automatic idleCycle(input logic [6:0] expCtrl, input string tag);
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, expCtrl, tag);
   endtask

   initial begin
      $display("[TB] hazard_control_unit bench, PERF_EN=%0d", PERF_EN);
      #2;
      rst = 1'b1;
      #1;
      pushExpected(EXP_DEF);
      checkOutput("reset");
      #4;
      rst = 1'b0;

      idleCycle(EXP_DEF, "idle");

      // Load-use on rt, then the load leaves EX.
      applyStimulus(1'b1, 1'b1, 3'b010, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, EXP_LU, "loaduse_rt");
      idleCycle(EXP_DEF, "after_loaduse");

      // No false stalls.
      applyStimulus(1'b1, 1'b1, 3'b010, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, EXP_DEF, "rt_not_used");
      applyStimulus(1'b1, 1'b1, 3'b011, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, EXP_DEF, "rd_mismatch");
      applyStimulus(1'b1, 1'b1, 3'b101, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, EXP_LU,  "loaduse_rs");
      applyStimulus(1'b1, 1'b0, 3'b101, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, EXP_DEF, "no_regwrite");

      // Multi-cycle op: three stall cycles then back to RUN.
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_MC, "mc_start");
      idleCycle(EXP_MC,  "mc_busy1");
      idleCycle(EXP_MC,  "mc_busy2");
      idleCycle(EXP_DEF, "mc_done");

      // Branch beats multi-cycle start and load-use.
      applyStimulus(1'b1, 1'b1, 3'b010, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, EXP_BR, "priority");
      idleCycle(EXP_DEF, "no_mc_entry");

      // Branch arriving in the last busy cycle is ignored.
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_MC, "mc2_start");
      idleCycle(EXP_MC, "mc2_busy1");
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, EXP_MC, "mc2_branch_ignored");
      idleCycle(EXP_DEF, "mc2_done");

      // Load-use held through a multi-cycle op is seen once RUN resumes.
      applyStimulus(1'b1, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, EXP_MC, "mc3_start_lu");
      applyStimulus(1'b1, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, EXP_MC, "mc3_busy1");
      applyStimulus(1'b1, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, EXP_MC, "mc3_busy2");
      applyStimulus(1'b1, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, EXP_LU, "mc3_lu_resume");
      idleCycle(EXP_DEF, "mc3_clear");

      // Reset in the second busy cycle takes effect without a clock.
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_MC, "mc4_start");
      idleCycle(EXP_MC, "mc4_busy1");
      idleCycle(EXP_MC, "mc4_busy2");
      #2;
      rst = 1'b1;
      modelStall = '0;
      modelFlush = '0;
      #1;
      pushExpected(EXP_DEF);
      checkOutput("async_reset_midop");
      #1;
      rst = 1'b0;
      idleCycle(EXP_DEF, "post_reset");
      idleCycle(EXP_DEF, "post_reset2");

      vectors++;
      assert (scoreboard.size() == 0)
      else begin
         miscompares++;
         $error("[TB] FAIL drain: observed %0d leftover entries, expected 0", scoreboard.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
